// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state
//   encoding, the default frame header byte, IMEM write-enable constants
//   and the running-checksum helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_LO = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_CNT_LO  = 3'd3,
        ST_CNT_HI  = 3'd4,
        ST_DATA    = 3'd5,
        ST_WRITE   = 3'd6,
        ST_CSUM    = 3'd7
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [3:0] WE_ALL        = 4'b1111;
    localparam logic [3:0] WE_NONE       = 4'b0000;

    // Frame checksum is a plain byte-wise XOR over address, count and data.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the loader's byte-stream handshake, the IMEM write port and the
//   status flags.
//   Stream : DataIn[7:0], DataInValid (source -> loader), DataInReady (loader -> source)
//   IMEM   : WE[3:0], AddrToMem[ADDR_WIDTH-1:0], WriteData[31:0] (loader -> IMEM)
//   Status : Busy, Done, Error (loader -> core)
//   Modports: slave = loader side, master = stream source / core side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            DataIn;
    logic                  DataInValid;
    logic                  DataInReady;
    logic [3:0]            WE;
    logic [ADDR_WIDTH-1:0] AddrToMem;
    logic [31:0]           WriteData;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport slave (
        input  DataIn, DataInValid,
        output DataInReady, WE, AddrToMem, WriteData, Busy, Done, Error
    );

    modport master (
        output DataIn, DataInValid,
        input  DataInReady, WE, AddrToMem, WriteData, Busy, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed byte stream (SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI,
//   N*4 data bytes, CSUM), packs little-endian 32-bit words and writes them
//   to consecutive IMEM word addresses. Busy stays high for the whole frame
//   so the core can be stalled; Done / Error pulse for one cycle at the end.
//   Ports:
//     Clk      - system clock, everything on posedge
//     Reset_n  - synchronous active-low reset
//     bus      - imem_loader_if.slave (stream in, IMEM write port, status)
//   Build option:
//     IMEM_LOADER_TIMEOUT_EN - when defined, an inter-byte counter aborts a
//     stalled frame with an Error pulse after TIMEOUT_CYCLES idle cycles.
//     When undefined, TIMEOUT_CYCLES is unused and a stalled frame waits.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 12,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    imem_loader_if.slave  bus
);

    state_e                state_q, state_d;
    logic [7:0]            addr_lo_q, addr_lo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_lo_q, cnt_lo_d;
    logic [15:0]           rem_q, rem_d;
    logic [23:0]           shift_q, shift_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [3:0]            we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_to_mem_q, addr_to_mem_d;
    logic [31:0]           write_data_q, write_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;

    logic                  accept_s;
    logic [15:0]           addr_field_s;
    logic [15:0]           cnt_field_s;
    logic                  unused_addr_s;

    assign accept_s     = bus.DataInValid & ready_q;
    assign addr_field_s = {bus.DataIn, addr_lo_q};
    assign cnt_field_s  = {bus.DataIn, cnt_lo_q};
    // Address bits above ADDR_WIDTH are accepted on the wire but discarded.
    assign unused_addr_s = ^addr_field_s;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
`else
    logic unused_tmo_s;
    assign unused_tmo_s = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic for the frame parser and word packer.
    always_comb begin
        state_d       = state_q;
        addr_lo_d     = addr_lo_q;
        addr_d        = addr_q;
        cnt_lo_d      = cnt_lo_q;
        rem_d         = rem_q;
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        csum_d        = csum_q;
        we_d          = WE_NONE;
        addr_to_mem_d = addr_to_mem_q;
        write_data_d  = write_data_q;
        done_d        = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Anything other than the header byte is swallowed here.
                if (accept_s && (bus.DataIn == SYNC_BYTE)) begin
                    csum_d  = 8'h00;
                    state_d = ST_ADDR_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (accept_s) begin
                    addr_lo_d = bus.DataIn;
                    csum_d    = csum_step(csum_q, bus.DataIn);
                    state_d   = ST_ADDR_HI;
                end else begin
                    state_d = ST_ADDR_LO;
                end
            end
            ST_ADDR_HI: begin
                if (accept_s) begin
                    addr_d  = addr_field_s[ADDR_WIDTH-1:0];
                    csum_d  = csum_step(csum_q, bus.DataIn);
                    state_d = ST_CNT_LO;
                end else begin
                    state_d = ST_ADDR_HI;
                end
            end
            ST_CNT_LO: begin
                if (accept_s) begin
                    cnt_lo_d = bus.DataIn;
                    csum_d   = csum_step(csum_q, bus.DataIn);
                    state_d  = ST_CNT_HI;
                end else begin
                    state_d = ST_CNT_LO;
                end
            end
            ST_CNT_HI: begin
                if (accept_s) begin
                    rem_d      = cnt_field_s;
                    byte_idx_d = 2'd0;
                    csum_d     = csum_step(csum_q, bus.DataIn);
                    state_d    = (cnt_field_s == 16'd0) ? ST_CSUM : ST_DATA;
                end else begin
                    state_d = ST_CNT_HI;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    // Bytes enter at the top so byte0 ends up in bits [7:0].
                    shift_d    = {bus.DataIn, shift_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    csum_d     = csum_step(csum_q, bus.DataIn);
                    if (byte_idx_q == 2'd3) begin
                        we_d          = WE_ALL;
                        addr_to_mem_d = addr_q;
                        write_data_d  = {bus.DataIn, shift_q};
                        state_d       = ST_WRITE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally at 2^ADDR_WIDTH.
                addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                rem_d   = rem_q - 16'd1;
                state_d = (rem_q == 16'd1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.DataIn == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
        // Idle counter restarts on every accepted byte and only runs mid-frame.
        if (accept_s || !busy_q) begin
            tmo_d = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
        if (busy_q && !accept_s && (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            we_d    = WE_NONE;
            tmo_d   = 32'd0;
        end else begin
            tmo_d = tmo_d;
        end
`endif

        // Status and handshake are registered from the next state so they
        // line up with the state they describe.
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d != ST_WRITE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            addr_lo_q     <= 8'h00;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            cnt_lo_q      <= 8'h00;
            rem_q         <= 16'd0;
            shift_q       <= 24'd0;
            byte_idx_q    <= 2'd0;
            csum_q        <= 8'h00;
            we_q          <= WE_NONE;
            addr_to_mem_q <= {ADDR_WIDTH{1'b0}};
            write_data_q  <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            ready_q       <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            tmo_q         <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            addr_lo_q     <= addr_lo_d;
            addr_q        <= addr_d;
            cnt_lo_q      <= cnt_lo_d;
            rem_q         <= rem_d;
            shift_q       <= shift_d;
            byte_idx_q    <= byte_idx_d;
            csum_q        <= csum_d;
            we_q          <= we_d;
            addr_to_mem_q <= addr_to_mem_d;
            write_data_q  <= write_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            ready_q       <= ready_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign bus.DataInReady = ready_q;
    assign bus.WE          = we_q;
    assign bus.AddrToMem   = addr_to_mem_q;
    assign bus.WriteData   = write_data_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Error       = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed frames are driven into the loader; every expected IMEM write,
//   Done and Error is pushed into a queue and a negedge monitor pops and
//   compares each one as the DUT presents it.
module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if #(.ADDR_WIDTH(12)) bus ();

    imem_loader #(
        .ADDR_WIDTH     (12),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare every DUT event against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.Done && bus.Error) begin
                checks++;
                failures++;
                $display("FAIL done_and_error: both pulses high together");
            end
            if (bus.WE != 4'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: WE=%h addr=%h data=%h, none expected",
                             bus.WE, bus.AddrToMem, bus.WriteData);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_WR || bus.WE != 4'hF || bus.AddrToMem != e.addr ||
                        bus.WriteData != e.data) begin
                        failures++;
                        $display("FAIL write: got WE=%h addr=%h data=%h, want kind=%0d WE=f addr=%h data=%h",
                                 bus.WE, bus.AddrToMem, bus.WriteData, e.kind, e.addr, e.data);
                    end
                end
            end
            if (bus.Done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: Done=1, nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_DONE) begin
                        failures++;
                        $display("FAIL done: got Done, want kind=%0d", e.kind);
                    end
                end
            end
            if (bus.Error) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_error: Error=1, nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_ERR) begin
                        failures++;
                        $display("FAIL error: got Error, want kind=%0d", e.kind);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic expect_write(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_pulse(input logic [1:0] k);
        exp_t e;
        e.kind = k; e.addr = 12'h000; e.data = 32'h0;
        exp_q.push_back(e);
    endtask

    // Drive one byte from a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.DataInValid = 1'b0;
                @(negedge clk);
            end
        end
        bus.DataIn      = b;
        bus.DataInValid = 1'b1;
        while (!bus.DataInReady && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: DataInReady=0 for 100 cycles, want 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.DataInValid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input bit gaps);
        foreach (seq[i]) send_byte(seq[i], gaps);
    endtask

    // Give outstanding expectations a bounded number of cycles to appear.
    task automatic wait_drain(input string name, input int cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [7:0] fr[$];

    initial begin
        bus.DataIn      = 8'h00;
        bus.DataInValid = 1'b0;
        rst_n           = 1'b0;

        // Reset: two cycles low, all outputs cleared, ready one cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",    32'(bus.WE), 32'h0);
        check("rst_addr",  32'(bus.AddrToMem), 32'h0);
        check("rst_wdata", bus.WriteData, 32'h0);
        check("rst_flags", {28'h0, bus.Busy, bus.Done, bus.Error, bus.DataInReady}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.DataInReady), 32'h1);

        // Two-word frame at 0x010; checksum 0x38 worked out by hand.
        expect_write(12'h010, 32'h12345678);
        expect_write(12'h011, 32'hDEADBEEF);
        expect_pulse(K_DONE);
        send_byte(8'hA5, 1'b0);
        check("busy_after_sync", 32'(bus.Busy), 32'h1);
        fr = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_seq(fr, 1'b0);
        check("we_latency", 32'(bus.WE), 32'hF);
        check("ready_in_write", 32'(bus.DataInReady), 32'h0);
        fr = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_seq(fr, 1'b0);
        check("busy_after_done", 32'(bus.Busy), 32'h0);
        wait_drain("frame_a_drain", 10);
        check("addr_hold", 32'(bus.AddrToMem), 32'h011);
        check("wdata_hold", bus.WriteData, 32'hDEADBEEF);

        // Address 0xFFF wraps to 0x000 on the second word; checksum 0x7A.
        expect_write(12'hFFF, 32'h44332211);
        expect_write(12'h000, 32'h88776655);
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h7A};
        send_seq(fr, 1'b0);
        wait_drain("wrap_drain", 10);

        // Upper address byte bits beyond 12 are ignored: field 0xF020 -> 0x020.
        expect_write(12'h020, 32'hDDCCBBAA);
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'h20, 8'hF0, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hD1};
        send_seq(fr, 1'b0);
        wait_drain("upper_addr_drain", 10);

        // Zero-word frame: Done with no writes; then bad checksum: Error only.
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(fr, 1'b0);
        wait_drain("n0_done_drain", 10);
        expect_pulse(K_ERR);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_seq(fr, 1'b0);
        check("busy_after_error", 32'(bus.Busy), 32'h0);
        wait_drain("n0_error_drain", 10);

        // Junk before the header is dropped without raising Busy.
        fr = '{8'h00, 8'hFF, 8'h5A};
        foreach (fr[i]) begin
            send_byte(fr[i], 1'b0);
            check("junk_busy", 32'(bus.Busy), 32'h0);
        end
        expect_write(12'h020, 32'hDDCCBBAA);
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21};
        send_seq(fr, 1'b0);
        wait_drain("after_junk_drain", 10);

        // Same two-word frame with random valid gaps gives identical writes.
        expect_write(12'h010, 32'h12345678);
        expect_write(12'h011, 32'hDEADBEEF);
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_seq(fr, 1'b1);
        wait_drain("gaps_drain", 10);

        // Reset after two data bytes: frame aborts silently.
        fr = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(fr, 1'b0);
        check("busy_mid_frame", 32'(bus.Busy), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(bus.Busy), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", 32'(exp_q.size()), 32'h0);
        // Loader is usable again straight after the abort.
        expect_pulse(K_DONE);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(fr, 1'b0);
        wait_drain("post_abort_drain", 10);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // Stall mid-header for more than 50 cycles: Error pulse, Busy drops.
        expect_pulse(K_ERR);
        fr = '{8'hA5, 8'h40, 8'h00};
        send_seq(fr, 1'b0);
        wait_drain("timeout_drain", 60);
        check("timeout_busy", 32'(bus.Busy), 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
